// File: rtl/sweep_sequencer.sv
// Switch-sweep sequencer: steps a 4-way RF switch through the enabled states,
// triggers the VNA in each and waits for its acquisition-complete edge.
//
// Optional feature (macro SWEEP_TIMEOUT_EN): acquisition watchdog in WAIT_ACQ.
//
// Ports:
//   clk_50       - clock, all logic on the rising edge
//   rst_n        - asynchronous active-low reset
//   start        - one-cycle sweep start request (ignored while busy)
//   stop         - one-cycle abort, wins over start
//   loop         - restart the sweep after completion when high
//   mask[3:0]    - enabled switch states, latched at start
//   acq_ready    - asynchronous acquisition-complete level from the VNA
//   switch_state - demanded switch position (valid while state_req is high)
//   state_req    - one-cycle new-state strobe to the switcher
//   vna_trig     - VNA trigger pulse
//   busy         - high whenever the FSM is not in IDLE
//   sweep_done   - one-cycle pulse at sweep completion
//   timeout      - one-cycle watchdog pulse (tied low without the macro)
//   sweep_count  - completed sweeps, wraps 255 -> 0

module sweep_sequencer #(
    parameter logic [27:0] SETTLE_CYCLES  = 28'd500000,
    parameter logic [7:0]  TRIG_WIDTH     = 8'd50,
    parameter logic [27:0] TIMEOUT_CYCLES = 28'd50000000
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    input  logic [3:0] mask,
    input  logic       acq_ready,
    output logic [1:0] switch_state,
    output logic       state_req,
    output logic       vna_trig,
    output logic       busy,
    output logic       sweep_done,
    output logic       timeout,
    output logic [7:0] sweep_count
);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SETTLE,
        TRIGGER,
        WAIT_ACQ,
        NEXT
    } state_t;

    localparam logic [27:0] SETTLE_LAST = SETTLE_CYCLES - 28'd1;
    localparam logic [27:0] TRIG_LAST   = {20'd0, TRIG_WIDTH} - 28'd1;

    state_t      state;
    state_t      nstate;
    logic [3:0]  mask_q;
    logic [1:0]  idx;
    logic [27:0] cnt;
    logic        acq_s1;
    logic        acq_s2;
    logic        acq_s3;
    logic        acq_evt;
    logic [2:0]  first_in;
    logic [2:0]  first_q;
    logic [2:0]  nxt;

    // Lowest set bit of m at or above position from; bit 2 of the
    // result flags that one was found.
    function automatic logic [2:0] pick(input logic [3:0] m,
                                        input logic [2:0] from);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (3'(i) >= from)) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

    assign first_in = pick(mask, 3'd0);
    assign first_q  = pick(mask_q, 3'd0);
    assign nxt      = pick(mask_q, {1'b0, idx} + 3'd1);

    // Two flops for metastability, a third to find the rising edge.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            acq_s1 <= 1'b0;
            acq_s2 <= 1'b0;
            acq_s3 <= 1'b0;
        end else begin
            acq_s1 <= acq_ready;
            acq_s2 <= acq_s1;
            acq_s3 <= acq_s2;
        end
    end

    assign acq_evt = acq_s2 & ~acq_s3;

    // State register
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    // Next-state logic
    always_comb begin
        nstate = state;
        if (stop) begin
            nstate = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && (mask != 4'd0)) begin
                        nstate = SELECT;
                    end
                end
                SELECT: begin
                    nstate = SETTLE;
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        nstate = TRIGGER;
                    end
                end
                TRIGGER: begin
                    if (cnt == TRIG_LAST) begin
                        nstate = WAIT_ACQ;
                    end
                end
                WAIT_ACQ: begin
                    if (acq_evt) begin
                        nstate = NEXT;
`ifdef SWEEP_TIMEOUT_EN
                    end else if (cnt == TIMEOUT_CYCLES) begin
                        nstate = IDLE;
`endif
                    end
                end
                NEXT: begin
                    if (nxt[2] || loop) begin
                        nstate = SELECT;
                    end else begin
                        nstate = IDLE;
                    end
                end
                default: begin
                    nstate = IDLE;
                end
            endcase
        end
    end

    // Output decode; pulses are suppressed when stop aborts the cycle
    // so they stay consistent with the datapath, which also holds.
    always_comb begin
        busy       = (state != IDLE);
        vna_trig   = (state == TRIGGER);
        sweep_done = (state == NEXT) && !nxt[2] && !stop;
`ifdef SWEEP_TIMEOUT_EN
        timeout    = (state == WAIT_ACQ) && (cnt == TIMEOUT_CYCLES)
                     && !acq_evt && !stop;
`else
        timeout    = 1'b0;
`endif
    end

    // Datapath: latched mask, index, cycle counter and registered outputs.
    // switch_state and state_req update on the same edge so the switcher
    // sees a valid position while the strobe is high.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            mask_q       <= 4'd0;
            idx          <= 2'd0;
            cnt          <= 28'd0;
            switch_state <= 2'd0;
            state_req    <= 1'b0;
            sweep_count  <= 8'd0;
        end else begin
            state_req <= 1'b0;
            if (!stop) begin
                unique case (state)
                    IDLE: begin
                        if (start && (mask != 4'd0)) begin
                            mask_q <= mask;
                            idx    <= first_in[1:0];
                        end
                    end
                    SELECT: begin
                        switch_state <= idx;
                        state_req    <= 1'b1;
                        cnt          <= 28'd0;
                    end
                    SETTLE: begin
                        cnt <= (cnt == SETTLE_LAST) ? 28'd0 : cnt + 28'd1;
                    end
                    TRIGGER: begin
                        cnt <= (cnt == TRIG_LAST) ? 28'd0 : cnt + 28'd1;
                    end
                    WAIT_ACQ: begin
                        // Saturate so an endless wait cannot wrap.
                        if (cnt != TIMEOUT_CYCLES) begin
                            cnt <= cnt + 28'd1;
                        end
                    end
                    NEXT: begin
                        if (nxt[2]) begin
                            idx <= nxt[1:0];
                        end else begin
                            sweep_count <= sweep_count + 8'd1;
                            idx         <= first_q[1:0];
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sweep_sequencer.sv
// Self-checking bench for sweep_sequencer with a behavioural model of the
// expected switch order, settle/trigger timing and sweep counting.

module tb_sweep_sequencer;

    logic       clk_50;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       loop;
    logic [3:0] mask;
    logic       acq_ready;
    logic [1:0] switch_state;
    logic       state_req;
    logic       vna_trig;
    logic       busy;
    logic       sweep_done;
    logic       timeout;
    logic [7:0] sweep_count;

    localparam int SETTLE = 4;
    localparam int TRIGW  = 2;
    localparam int TMO    = 20;

    sweep_sequencer #(
        .SETTLE_CYCLES (28'd4),
        .TRIG_WIDTH    (8'd2),
        .TIMEOUT_CYCLES(28'd20)
    ) dut (
        .clk_50      (clk_50),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .loop        (loop),
        .mask        (mask),
        .acq_ready   (acq_ready),
        .switch_state(switch_state),
        .state_req   (state_req),
        .vna_trig    (vna_trig),
        .busy        (busy),
        .sweep_done  (sweep_done),
        .timeout     (timeout),
        .sweep_count (sweep_count)
    );

    initial clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    int checks = 0;
    int errors = 0;

    // Observation log gathered on falling edges.
    int cyc = 0;
    int last_req = 0;
    int trig_run = 0;
    int sw_q[$];
    int trig_len_q[$];
    int settle_q[$];
    int done_cnt = 0;
    int to_cnt = 0;
    int req_cnt = 0;

    logic [7:0] model_cnt;

    always @(negedge clk_50) begin
        cyc++;
        if (!rst_n) begin
            trig_run = 0;
        end else begin
            if (state_req) begin
                sw_q.push_back(int'(switch_state));
                last_req = cyc;
                req_cnt++;
            end
            if (vna_trig) begin
                if (trig_run == 0) settle_q.push_back(cyc - last_req);
                trig_run++;
            end else if (trig_run != 0) begin
                trig_len_q.push_back(trig_run);
                trig_run = 0;
            end
            if (sweep_done) done_cnt++;
            if (timeout) to_cnt++;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        sw_q.delete();
        trig_len_q.delete();
        settle_q.delete();
        done_cnt = 0;
        to_cnt = 0;
        req_cnt = 0;
    endtask

    task automatic start_sweep(input logic [3:0] m);
        @(negedge clk_50);
        mask = m;
        start = 1'b1;
        @(negedge clk_50);
        start = 1'b0;
    endtask

    task automatic wait_trig_fall(output bit ok);
        bit seen;
        seen = 0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_50);
            if (vna_trig) seen = 1;
            else if (seen) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_sig(input string tag, input int which);
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_50);
            if ((which == 0 && !busy) || (which == 1 && state_req) ||
                (which == 2 && vna_trig)) begin
                ok = 1;
                break;
            end
        end
        chk(tag, int'(ok), 1);
    endtask

    task automatic pulse_acq();
        repeat ($urandom_range(0, 3)) @(negedge clk_50);
        acq_ready = 1'b1;
        repeat (2) @(negedge clk_50);
        acq_ready = 1'b0;
    endtask

    task automatic run_acqs(input int n, input bit disturb);
        bit ok;
        for (int i = 0; i < n; i++) begin
            wait_trig_fall(ok);
            if (!ok) begin
                chk("trig_seen", 0, 1);
                return;
            end
            if (disturb && i == 0) begin
                // start with a different mask while busy must change nothing
                mask = 4'($urandom);
                start = 1'b1;
                @(negedge clk_50);
                start = 1'b0;
            end
            pulse_acq();
        end
    endtask

    task automatic wait_done(input int target);
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_50);
            if (done_cnt >= target) begin
                ok = 1;
                break;
            end
        end
        chk("done_reached", int'(ok), 1);
        @(negedge clk_50);
    endtask

    // Model: one sweep visits the set bits of m in ascending order, each
    // with a SETTLE-cycle settle and a TRIGW-cycle trigger.
    task automatic check_sweep(input string tag, input logic [3:0] m);
        int exp_q[$];
        bit t_ok;
        bit s_ok;
        for (int b = 0; b < 4; b++) if (m[b]) exp_q.push_back(b);
        chk({tag, "_nreq"}, sw_q.size(), exp_q.size());
        if (sw_q.size() == exp_q.size()) begin
            for (int i = 0; i < exp_q.size(); i++)
                chk({tag, "_sw"}, sw_q[i], exp_q[i]);
        end
        t_ok = (trig_len_q.size() == exp_q.size());
        foreach (trig_len_q[i]) if (trig_len_q[i] != TRIGW) t_ok = 0;
        chk({tag, "_trig_width"}, int'(t_ok), 1);
        s_ok = (settle_q.size() == exp_q.size());
        foreach (settle_q[i]) if (settle_q[i] != SETTLE) s_ok = 0;
        chk({tag, "_settle"}, int'(s_ok), 1);
        chk({tag, "_done"}, done_cnt, 1);
        chk({tag, "_count"}, int'(sweep_count), int'(model_cnt));
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_switch_state"}, int'(switch_state), 0);
        chk({tag, "_state_req"}, int'(state_req), 0);
        chk({tag, "_vna_trig"}, int'(vna_trig), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_sweep_done"}, int'(sweep_done), 0);
        chk({tag, "_timeout"}, int'(timeout), 0);
        chk({tag, "_sweep_count"}, int'(sweep_count), 0);
    endtask

    initial begin
        logic [3:0] m;
        logic [7:0] cnt_before;
        bit any_nz;
        bit busy_seen;
        int k;
        int popc;

        rst_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        loop = 1'b0;
        mask = 4'd0;
        acq_ready = 1'b0;
        model_cnt = 8'd0;
        repeat (3) @(negedge clk_50);
        check_reset_outs("rst");
        rst_n = 1'b1;
        @(negedge clk_50);
        chk("post_rst_busy", int'(busy), 0);

        // Directed two-state sweep
        clear_mon();
        start_sweep(4'b1010);
        run_acqs(2, 0);
        wait_sig("idle_a", 0);
        @(negedge clk_50);
        model_cnt++;
        check_sweep("m1010", 4'b1010);

        // Randomised masks, with an ignored start mid-sweep
        for (int r = 0; r < 4; r++) begin
            m = 4'($urandom_range(1, 15));
            popc = $countones(m);
            clear_mon();
            start_sweep(m);
            run_acqs(popc, 1);
            wait_sig("idle_r", 0);
            @(negedge clk_50);
            model_cnt++;
            check_sweep("rand", m);
        end

        // Empty mask: start ignored
        clear_mon();
        start_sweep(4'b0000);
        busy_seen = 0;
        repeat (10) begin
            @(negedge clk_50);
            if (busy) busy_seen = 1;
        end
        chk("m0_busy", int'(busy_seen), 0);
        chk("m0_req", req_cnt, 0);

        // Looping single-state sweep, then run on to the 8-bit wrap
        clear_mon();
        loop = 1'b1;
        start_sweep(4'b0001);
        run_acqs(3, 0);
        wait_done(3);
        model_cnt += 8'd3;
        chk("loop_done", done_cnt, 3);
        chk("loop_count", int'(sweep_count), int'(model_cnt));
        k = 255 - int'(model_cnt);
        run_acqs(k, 0);
        wait_done(3 + k);
        chk("count_255", int'(sweep_count), 255);
        run_acqs(1, 0);
        wait_done(4 + k);
        model_cnt = 8'd0;
        chk("count_wrap", int'(sweep_count), 0);
        any_nz = 0;
        foreach (sw_q[i]) if (sw_q[i] != 0) any_nz = 1;
        chk("loop_sw_zero", int'(any_nz), 0);
        chk("loop_busy", int'(busy), 1);
        loop = 1'b0;
        stop = 1'b1;
        @(negedge clk_50);
        stop = 1'b0;
        chk("loop_stop_busy", int'(busy), 0);

        // Stop during TRIGGER
        m = 4'($urandom_range(1, 15));
        clear_mon();
        start_sweep(m);
        wait_sig("trig_high", 2);
        stop = 1'b1;
        @(negedge clk_50);
        stop = 1'b0;
        chk("stop_trig", int'(vna_trig), 0);
        chk("stop_busy", int'(busy), 0);
        k = 0;
        while (!m[k]) k++;
        chk("stop_sw_hold", int'(switch_state), k);
        @(negedge clk_50);
        chk("stop_stay_idle", int'(busy), 0);

        // start and stop together in IDLE
        clear_mon();
        mask = 4'b1111;
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk_50);
        start = 1'b0;
        stop = 1'b0;
        chk("startstop_busy", int'(busy), 0);
        repeat (3) @(negedge clk_50);
        chk("startstop_req", req_cnt, 0);

        // Acquisition edge during SETTLE must not advance the sweep
        clear_mon();
        cnt_before = sweep_count;
        start_sweep(4'b0100);
        wait_sig("req_settle", 1);
        acq_ready = 1'b1;
        repeat (2) @(negedge clk_50);
        acq_ready = 1'b0;
        begin
            bit ok;
            wait_trig_fall(ok);
            chk("settle_trig", int'(ok), 1);
        end
`ifdef SWEEP_TIMEOUT_EN
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk_50);
            if (timeout) begin
                k = i;
                break;
            end
        end
        chk("timeout_delay", k, TMO);
        @(negedge clk_50);
        chk("timeout_idle", int'(busy), 0);
        chk("timeout_count", int'(sweep_count), int'(cnt_before));
        chk("timeout_pulses", to_cnt, 1);
`else
        repeat (40) @(negedge clk_50);
        chk("noto_busy", int'(busy), 1);
        chk("noto_timeout", to_cnt, 0);
        chk("noto_done", done_cnt, 0);
        chk("noto_req", req_cnt, 1);
        stop = 1'b1;
        @(negedge clk_50);
        stop = 1'b0;
`endif

        // Reset mid-SETTLE with a non-zero position and count
        loop = 1'b1;
        start_sweep(4'b0001);
        run_acqs(1, 0);
        wait_done(1 + done_cnt);
        loop = 1'b0;
        stop = 1'b1;
        @(negedge clk_50);
        stop = 1'b0;
        start_sweep(4'b0110);
        wait_sig("req_rst", 1);
        chk("pre_rst_sw", int'(switch_state), 1);
        @(negedge clk_50);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outs("async_rst");
        @(negedge clk_50);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_50);
        chk("post_async_busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
